// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the two-requester DDR local-port arbiter.
package ddr_arb_pkg;

    localparam int DDR_ADDR_W = 26;
    localparam int DDR_DATA_W = 128;
    localparam int DDR_BE_W   = 16;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_ARB,
        ST_WBURST
    } arb_state_t;

    typedef struct packed {
        logic       port;
        logic [2:0] beats;
    } tag_t;

    // A size of 0 means a single beat; oversize requests are clipped to the legal maximum.
    function automatic logic [2:0] norm_size(input logic [2:0] size, input logic [2:0] max_beats);
        if (size == 3'd0) return 3'd1;
        if (size > max_beats) return max_beats;
        return size;
    endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// Ordered return-tag FIFO: one entry per outstanding read command, push and pop may coincide.
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  tag_t push_data,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    tag_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_local_arbiter.sv
// Round-robin arbiter for two masters on one DDR local port, with write-burst locking and read-return routing.
// Define DDR_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module ddr_local_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int TAG_DEPTH = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0_valid,
    input  logic                  r0_write,
    input  logic [DDR_ADDR_W-1:0] r0_addr,
    input  logic [2:0]            r0_size,
    input  logic [DDR_DATA_W-1:0] r0_wdata,
    input  logic [DDR_BE_W-1:0]   r0_be,
    output logic                  r0_ready,
    output logic                  r0_rsp_valid,
    output logic [DDR_DATA_W-1:0] r0_rsp_data,
    input  logic                  r1_valid,
    input  logic                  r1_write,
    input  logic [DDR_ADDR_W-1:0] r1_addr,
    input  logic [2:0]            r1_size,
    input  logic [DDR_DATA_W-1:0] r1_wdata,
    input  logic [DDR_BE_W-1:0]   r1_be,
    output logic                  r1_ready,
    output logic                  r1_rsp_valid,
    output logic [DDR_DATA_W-1:0] r1_rsp_data,
    output logic [DDR_ADDR_W-1:0] local_address,
    output logic                  local_write_req,
    output logic                  local_read_req,
    output logic                  local_burstbegin,
    output logic [DDR_DATA_W-1:0] local_wdata,
    output logic [DDR_BE_W-1:0]   local_be,
    output logic [2:0]            local_size,
    input  logic                  local_ready,
    input  logic                  local_rdata_valid,
    input  logic                  local_init_done,
    input  logic [DDR_DATA_W-1:0] local_rdata,
    output logic                  err_unexp_rdata
);

    localparam logic [2:0] MAX_B = 3'(MAX_BEATS);

    arb_state_t            state;
    logic                  lock_port;
    logic [2:0]            remaining;
    logic [2:0]            held_size;
    logic [DDR_ADDR_W-1:0] held_addr;
    logic [2:0]            head_cnt;

    logic                  fifo_full;
    logic                  fifo_empty;
    tag_t                  head;
    logic                  fifo_push;
    logic                  fifo_pop;

    logic                  elig0;
    logic                  elig1;
    logic                  arb_en;
    logic                  arb_sel;
    logic                  sel;
    logic                  cmd_valid;
    logic                  cmd_write;
    logic                  cmd_bb;
    logic [DDR_ADDR_W-1:0] cmd_addr;
    logic [2:0]            cmd_size;
    logic                  transfer;
    logic                  rsp_hit;

    // A read may only compete while there is room to remember where its data goes.
    assign elig0  = r0_valid & (r0_write | ~fifo_full);
    assign elig1  = r1_valid & (r1_write | ~fifo_full);
    assign arb_en = local_init_done & (state != ST_WBURST);

`ifdef DDR_ARB_FIXED_PRIO_EN
    assign arb_sel = ~elig0;
`else
    logic last;

    assign arb_sel = (elig0 & elig1) ? ~last : elig1;

    always_ff @(posedge clock) begin
        if (reset)         last <= 1'b1;
        else if (transfer) last <= sel;
    end
`endif

    always_comb begin
        sel       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_bb    = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        if (state == ST_WBURST) begin
            sel       = lock_port;
            cmd_valid = lock_port ? r1_valid : r0_valid;
            cmd_write = 1'b1;
            cmd_addr  = held_addr;
            cmd_size  = held_size;
        end else if (arb_en && (elig0 || elig1)) begin
            sel       = arb_sel;
            cmd_valid = 1'b1;
            cmd_bb    = 1'b1;
            cmd_write = arb_sel ? r1_write : r0_write;
            cmd_addr  = arb_sel ? r1_addr : r0_addr;
            cmd_size  = norm_size(arb_sel ? r1_size : r0_size, MAX_B);
        end
    end

    assign transfer         = cmd_valid & local_ready;
    assign r0_ready         = transfer & ~sel;
    assign r1_ready         = transfer & sel;
    assign local_address    = cmd_addr;
    assign local_size       = cmd_size;
    assign local_write_req  = cmd_valid & cmd_write;
    assign local_read_req   = cmd_valid & ~cmd_write;
    assign local_burstbegin = cmd_bb;
    assign local_wdata      = cmd_valid ? (sel ? r1_wdata : r0_wdata) : '0;
    assign local_be         = cmd_valid ? (sel ? r1_be : r0_be) : '0;

    assign fifo_push    = transfer & ~cmd_write;
    assign rsp_hit      = local_rdata_valid & ~fifo_empty;
    assign fifo_pop     = rsp_hit & ((head_cnt + 3'd1) == head.beats);
    assign r0_rsp_valid = rsp_hit & ~head.port;
    assign r1_rsp_valid = rsp_hit & head.port;
    assign r0_rsp_data  = local_rdata;
    assign r1_rsp_data  = local_rdata;

    ddr_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ('{port: sel, beats: cmd_size}),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The burst lock is only taken after beat 1 actually transfers; init_done falling mid-burst waits for ARB.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_INIT;
            lock_port       <= 1'b0;
            remaining       <= '0;
            held_size       <= '0;
            held_addr       <= '0;
            head_cnt        <= '0;
            err_unexp_rdata <= 1'b0;
        end else begin
            case (state)
                ST_INIT, ST_ARB: begin
                    state <= local_init_done ? ST_ARB : ST_INIT;
                    if (transfer && cmd_write && (cmd_size > 3'd1)) begin
                        state     <= ST_WBURST;
                        lock_port <= sel;
                        remaining <= cmd_size - 3'd1;
                        held_addr <= cmd_addr;
                        held_size <= cmd_size;
                    end
                end
                ST_WBURST: begin
                    if (transfer) begin
                        remaining <= remaining - 3'd1;
                        if (remaining == 3'd1) state <= ST_ARB;
                    end
                end
                default: state <= ST_INIT;
            endcase
            if (rsp_hit) head_cnt <= fifo_pop ? 3'd0 : head_cnt + 3'd1;
            if (local_rdata_valid && fifo_empty) err_unexp_rdata <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr_local_arbiter.sv
// Self-checking bench for ddr_local_arbiter: vector table for arbitration plus sequences for bursts, read routing and FIFO full.
module tb_ddr_local_arbiter;
    import ddr_arb_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         r0_valid, r0_write, r0_ready, r0_rsp_valid;
    logic [25:0]  r0_addr;
    logic [2:0]   r0_size;
    logic [127:0] r0_wdata, r0_rsp_data;
    logic [15:0]  r0_be;
    logic         r1_valid, r1_write, r1_ready, r1_rsp_valid;
    logic [25:0]  r1_addr;
    logic [2:0]   r1_size;
    logic [127:0] r1_wdata, r1_rsp_data;
    logic [15:0]  r1_be;
    logic [25:0]  local_address;
    logic         local_write_req, local_read_req, local_burstbegin;
    logic [127:0] local_wdata, local_rdata;
    logic [15:0]  local_be;
    logic [2:0]   local_size;
    logic         local_ready, local_rdata_valid, local_init_done;
    logic         err_unexp_rdata;

    int compared   = 0;
    int mismatched = 0;
    int exp_q[$];

    typedef struct {
        logic [4:0]  stim;
        logic [4:0]  expect_bits;
        logic [25:0] addr;
    } vec_t;

    vec_t vecs[11];

    always #5 clock = ~clock;

    ddr_local_arbiter dut (
        .clock             (clock),
        .reset             (reset),
        .r0_valid          (r0_valid),
        .r0_write          (r0_write),
        .r0_addr           (r0_addr),
        .r0_size           (r0_size),
        .r0_wdata          (r0_wdata),
        .r0_be             (r0_be),
        .r0_ready          (r0_ready),
        .r0_rsp_valid      (r0_rsp_valid),
        .r0_rsp_data       (r0_rsp_data),
        .r1_valid          (r1_valid),
        .r1_write          (r1_write),
        .r1_addr           (r1_addr),
        .r1_size           (r1_size),
        .r1_wdata          (r1_wdata),
        .r1_be             (r1_be),
        .r1_ready          (r1_ready),
        .r1_rsp_valid      (r1_rsp_valid),
        .r1_rsp_data       (r1_rsp_data),
        .local_address     (local_address),
        .local_write_req   (local_write_req),
        .local_read_req    (local_read_req),
        .local_burstbegin  (local_burstbegin),
        .local_wdata       (local_wdata),
        .local_be          (local_be),
        .local_size        (local_size),
        .local_ready       (local_ready),
        .local_rdata_valid (local_rdata_valid),
        .local_init_done   (local_init_done),
        .local_rdata       (local_rdata),
        .err_unexp_rdata   (err_unexp_rdata)
    );

    task automatic checkBit(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic w0, input logic [25:0] a0, input logic [2:0] s0,
                                 input logic v1, input logic w1, input logic [25:0] a1, input logic [2:0] s1,
                                 input logic lr);
        r0_valid = v0; r0_write = w0; r0_addr = a0; r0_size = s0;
        r1_valid = v1; r1_write = w1; r1_addr = a1; r1_size = s1;
        local_ready = lr;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 26'h0, 3'd0, 1'b0, 1'b0, 26'h0, 3'd0, 1'b1);
    endtask

    task automatic doReset();
        idle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
    endtask

    // Drives one controller return beat and checks it lands on the port the scoreboard predicts.
    task automatic returnBeat(input logic [127:0] data);
        int p;
        local_rdata_valid = 1'b1;
        local_rdata = data;
        #2;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL rsp_scoreboard: beat %0h arrived with no expected read", data);
        end else begin
            p = exp_q.pop_front();
            checkBit("rsp_valid0", r0_rsp_valid, p == 0);
            checkBit("rsp_valid1", r1_rsp_valid, p == 1);
            checkOutput("rsp_data", (p == 1) ? r1_rsp_data : r0_rsp_data, data);
        end
        nextCycle();
        local_rdata_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5'b11111, 5'b10101, 26'h10};
`ifdef DDR_ARB_FIXED_PRIO_EN
        vecs[1]  = '{5'b11111, 5'b10101, 26'h10};
`else
        vecs[1]  = '{5'b11111, 5'b01101, 26'h20};
`endif
        vecs[2]  = '{5'b11111, 5'b10101, 26'h10};
`ifdef DDR_ARB_FIXED_PRIO_EN
        vecs[3]  = '{5'b11111, 5'b10101, 26'h10};
`else
        vecs[3]  = '{5'b11111, 5'b01101, 26'h20};
`endif
        vecs[4]  = '{5'b11110, 5'b00101, 26'h10};
        vecs[5]  = '{5'b11111, 5'b10101, 26'h10};
        vecs[6]  = '{5'b00111, 5'b01101, 26'h20};
        vecs[7]  = '{5'b00001, 5'b00000, 26'h0};
        vecs[8]  = '{5'b00111, 5'b01101, 26'h20};
        vecs[9]  = '{5'b11111, 5'b10101, 26'h10};
        vecs[10] = '{5'b00111, 5'b01101, 26'h20};

        r0_wdata = 128'hA0; r0_be = 16'h000F;
        r1_wdata = 128'hA1; r1_be = 16'hF000;
        local_rdata_valid = 1'b0; local_rdata = '0; local_init_done = 1'b0;
        idle();
        reset = 1'b1;
        repeat (2) nextCycle();
        reset = 1'b0;
        #2;
        checkBit("rst_r0_ready", r0_ready, 1'b0);
        checkBit("rst_r1_ready", r1_ready, 1'b0);
        checkBit("rst_write_req", local_write_req, 1'b0);
        checkBit("rst_read_req", local_read_req, 1'b0);
        checkBit("rst_burstbegin", local_burstbegin, 1'b0);
        checkBit("rst_err", err_unexp_rdata, 1'b0);
        checkOutput("rst_addr", 128'(local_address), 128'h0);
        nextCycle();

        applyStimulus(1'b1, 1'b0, 26'h40, 3'd1, 1'b0, 1'b0, 26'h0, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            #2;
            checkBit("init_r0_ready", r0_ready, 1'b0);
            checkBit("init_read_req", local_read_req, 1'b0);
            nextCycle();
        end
        local_init_done = 1'b1;
        #2;
        checkBit("init_go_read_req", local_read_req, 1'b1);
        checkBit("init_go_r0_ready", r0_ready, 1'b1);
        checkOutput("init_go_addr", 128'(local_address), 128'h40);
        exp_q.push_back(0);
        nextCycle();
        idle();
        returnBeat(128'hD0);

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stim[4], vecs[i].stim[3], 26'h10, 3'd1,
                          vecs[i].stim[2], vecs[i].stim[1], 26'h20, 3'd1, vecs[i].stim[0]);
            #2;
            checkBit("vec_r0_ready", r0_ready, vecs[i].expect_bits[4]);
            checkBit("vec_r1_ready", r1_ready, vecs[i].expect_bits[3]);
            checkBit("vec_write_req", local_write_req, vecs[i].expect_bits[2]);
            checkBit("vec_read_req", local_read_req, vecs[i].expect_bits[1]);
            checkBit("vec_burstbegin", local_burstbegin, vecs[i].expect_bits[0]);
            checkOutput("vec_addr", 128'(local_address), 128'(vecs[i].addr));
            nextCycle();
        end

        // r0 write burst of 4 with r1 contending throughout and a one-cycle valid gap.
        applyStimulus(1'b1, 1'b1, 26'h100, 3'd4, 1'b1, 1'b1, 26'h20, 3'd1, 1'b1);
        r0_wdata = 128'hB1;
        #2;
        checkBit("wb1_r0_ready", r0_ready, 1'b1);
        checkBit("wb1_r1_ready", r1_ready, 1'b0);
        checkBit("wb1_burstbegin", local_burstbegin, 1'b1);
        checkOutput("wb1_size", 128'(local_size), 128'd4);
        checkOutput("wb1_addr", 128'(local_address), 128'h100);
        nextCycle();
        r0_addr = 26'h104; r0_size = 3'd0; r0_wdata = 128'hB2;
        #2;
        checkBit("wb2_r0_ready", r0_ready, 1'b1);
        checkBit("wb2_r1_ready", r1_ready, 1'b0);
        checkBit("wb2_burstbegin", local_burstbegin, 1'b0);
        checkOutput("wb2_addr", 128'(local_address), 128'h100);
        checkOutput("wb2_size", 128'(local_size), 128'd4);
        checkOutput("wb2_wdata", local_wdata, 128'hB2);
        nextCycle();
        r0_valid = 1'b0;
        #2;
        checkBit("wgap_r0_ready", r0_ready, 1'b0);
        checkBit("wgap_r1_ready", r1_ready, 1'b0);
        checkBit("wgap_write_req", local_write_req, 1'b0);
        nextCycle();
        r0_valid = 1'b1;
        for (int b = 3; b <= 4; b++) begin
            r0_wdata = 128'(32'hB0 + b);
            #2;
            checkBit("wbn_r0_ready", r0_ready, 1'b1);
            checkBit("wbn_r1_ready", r1_ready, 1'b0);
            checkOutput("wbn_wdata", local_wdata, 128'(32'hB0 + b));
            nextCycle();
        end
        applyStimulus(1'b1, 1'b1, 26'h10, 3'd1, 1'b1, 1'b1, 26'h20, 3'd1, 1'b1);
        #2;
`ifdef DDR_ARB_FIXED_PRIO_EN
        checkBit("wpost_r0_ready", r0_ready, 1'b1);
        checkBit("wpost_r1_ready", r1_ready, 1'b0);
`else
        checkBit("wpost_r0_ready", r0_ready, 1'b0);
        checkBit("wpost_r1_ready", r1_ready, 1'b1);
        checkOutput("wpost_addr", 128'(local_address), 128'h20);
`endif
        checkBit("wpost_burstbegin", local_burstbegin, 1'b1);
        nextCycle();

        applyStimulus(1'b1, 1'b0, 26'h200, 3'd2, 1'b0, 1'b0, 26'h0, 3'd0, 1'b1);
        #2;
        checkBit("rd2_r0_ready", r0_ready, 1'b1);
        checkBit("rd2_read_req", local_read_req, 1'b1);
        checkOutput("rd2_size", 128'(local_size), 128'd2);
        exp_q.push_back(0);
        exp_q.push_back(0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 26'h0, 3'd0, 1'b1, 1'b0, 26'h300, 3'd1, 1'b1);
        #2;
        checkBit("rd1_r1_ready", r1_ready, 1'b1);
        checkBit("rd1_read_req", local_read_req, 1'b1);
        checkOutput("rd1_addr", 128'(local_address), 128'h300);
        exp_q.push_back(1);
        nextCycle();
        idle();
        returnBeat(128'hAAAA);
        returnBeat(128'hBBBB);
        returnBeat(128'hCCCC);

        // Fill all tags, then show the blocked read yielding to a write until one tag retires.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 26'(32'h400 + i), 3'd1, 1'b0, 1'b0, 26'h0, 3'd0, 1'b1);
            #2;
            checkBit("fill_r0_ready", r0_ready, 1'b1);
            exp_q.push_back(0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 26'h500, 3'd1, 1'b1, 1'b1, 26'h600, 3'd1, 1'b1);
        #2;
        checkBit("full_r0_ready", r0_ready, 1'b0);
        checkBit("full_r1_ready", r1_ready, 1'b1);
        checkBit("full_write_req", local_write_req, 1'b1);
        checkBit("full_read_req", local_read_req, 1'b0);
        checkOutput("full_addr", 128'(local_address), 128'h600);
        nextCycle();
        r1_valid = 1'b0;
        #2;
        checkBit("stall_r0_ready", r0_ready, 1'b0);
        checkBit("stall_read_req", local_read_req, 1'b0);
        nextCycle();
        returnBeat(128'h1000);
        #2;
        checkBit("unstall_r0_ready", r0_ready, 1'b1);
        checkBit("unstall_read_req", local_read_req, 1'b1);
        checkOutput("unstall_addr", 128'(local_address), 128'h500);
        exp_q.push_back(0);
        nextCycle();
        idle();
        for (int i = 1; i <= 8; i++) returnBeat(128'(32'h1000 + i));

        local_rdata_valid = 1'b1;
        local_rdata = 128'hEE;
        #2;
        checkBit("unexp_rsp_valid0", r0_rsp_valid, 1'b0);
        checkBit("unexp_rsp_valid1", r1_rsp_valid, 1'b0);
        checkBit("unexp_err_before", err_unexp_rdata, 1'b0);
        nextCycle();
        local_rdata_valid = 1'b0;
        #2;
        checkBit("unexp_err_set", err_unexp_rdata, 1'b1);
        nextCycle();
        #2;
        checkBit("unexp_err_sticky", err_unexp_rdata, 1'b1);
        doReset();
        #2;
        checkBit("unexp_err_cleared", err_unexp_rdata, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ddr_local_arbiter.md
# ddr_local_arbiter

Two-requester arbiter sharing the single `ddr4_64bit` local (Avalon-style) port between two bus masters, e.g. the TileLink bridge and a debug/DMA engine. It performs round-robin command arbitration and locks the grant for the full write burst. It also keeps an ordered return-tag FIFO so that each `local_rdata_valid` beat goes back to the requester that issued the read. It sits between the requester adapters and the memory controller, in the controller's `phy_clk` domain.

## Interface
- `TAG_DEPTH`, 8: outstanding read commands tracked; power of two, ≥2.
- `MAX_BEATS`, 4: largest legal `size`.
- `clock`  in  1  controller `phy_clk`; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rN_valid`  in  1  requester N (N=0,1) has a beat.
- `rN_write`  in  1  1=write, 0=read; sampled on first beat.
- `rN_addr`  in  26  beat address; sampled on first beat.
- `rN_size`  in  3  burst beats 1..MAX_BEATS; 0 treated as 1; sampled on first beat.
- `rN_wdata`  in  128  write data.
- `rN_be`  in  16  byte enables.
- `rN_ready`  out  1  beat accepted this cycle.
- `rN_rsp_valid`  out  1  read beat for requester N.
- `rN_rsp_data`  out  128  read data.
- `local_*`  out  (26/1/1/1/128/16/3): address, write_req, read_req, burstbegin, wdata, be, size to the controller.
- `local_ready`, `local_rdata_valid`, `local_init_done`  in  1 each.
- `local_rdata`  in  128.
- `err_unexp_rdata`  out  1  sticky; set when a read beat arrives while the tag FIFO is empty.

## Operation
- States: INIT, ARB, WBURST.
- INIT: all ready/request outputs are 0. Move to ARB on the first cycle `local_init_done`=1.
- ARB: pick a winner among valid requesters with no extra cycle.
  - If both are valid, the requester not granted last wins; the `last` pointer resets to 1, so requester 0 wins the first tie.
  - The winner's fields drive `local_*`, with `local_burstbegin`=1 and `write_req`/`read_req` set per `rN_write`.
  - A beat transfers when `local_ready`=1; then `rN_ready`=1 and `last` updates.
- A read is one command. On transfer, push {port, size} to the tag FIFO.
  - A read is not eligible while the FIFO is full; the other requester may still win if it is valid.
- A write with size>1: after beat 1 transfers, go to WBURST with `remaining`=size-1.
  - In WBURST only the locked requester is granted; `burstbegin`=0; address and size are held from beat 1.
  - Each transfer decrements `remaining`. At 0, return to ARB.
  - A gap in `rN_valid` stalls the burst; it never interleaves another requester.
- Read return: route each `local_rdata_valid` beat combinationally to the port at the FIFO head, then decrement the head's beat count.
  - Pop the FIFO on the last beat.
  - A pop and a push in the same cycle are both honoured.
- A `local_init_done` fall returns to INIT only from ARB. WBURST completes first.

## Timing
- Command path is combinational: `rN_*` → `local_*`, and `local_ready` → `rN_ready`. Zero added latency.
- Back-to-back single-beat commands run at one per cycle.
- Read response path is combinational; `rN_rsp_data` = `local_rdata`.
- After reset, every output is 0, the FIFO is empty and `err_unexp_rdata`=0. Reset mid-burst abandons the burst.

## Configuration
- `DDR_ARB_FIXED_PRIO_EN` defined: requester 0 always wins ties, and the `last` pointer is removed.
- Undefined: round-robin as described above.

## Structure
- Shared package `ddr_arb_pkg` holds:
  - the state enum;
  - the tag struct {port 1b, beats 3b};
  - constants `DDR_ADDR_W`=26, `DDR_DATA_W`=128, `DDR_BE_W`=16.
- One sub-module, `ddr_arb_tag_fifo`: synchronous FIFO with parameter DEPTH, full/empty, and simultaneous push/pop.

## Test plan
- Hold `local_init_done`=0 with `r0_valid`=1 for 10 cycles → `r0_ready` and `local_read_req` stay 0. Raise init_done → the request issues the same cycle.
- Both requesters issue continuous single-beat writes, `local_ready`=1 → grants alternate 0,1,0,1, with the first grant to 0. With `DDR_ARB_FIXED_PRIO_EN` defined → requester 0 only.
- r0 writes size 4 at 0x100 while r1 is valid throughout → four r0 beats, address 0x100 held, burstbegin only on beat 1, then r1 is granted.
- r0 reads size 2, then r1 reads size 1. Controller returns 3 beats A,B,C → r0 gets A,B; r1 gets C.
- Issue 8 reads with no returns → the 9th read is stalled while a write from the other requester proceeds. One return pop → the stalled read issues.
- Pulse `local_rdata_valid` with the FIFO empty → `err_unexp_rdata`=1 and no `rN_rsp_valid` asserts.
